// File: rtl/mod_n_pkg.sv
// Shared definitions for the mod-N counter family: modulus limits and the
// count-width helper used to size counter state from the modulus.
package mod_n_pkg;

    localparam int MOD_N_MIN = 2;
    localparam int MOD_N_MAX = 65536;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/d_ff_sync.sv
// 1-bit D flip-flop with synchronous active-high clear; synchronous sibling
// of the asynchronous-clear flop used elsewhere in the counter family.
module d_ff_sync (
    input  logic clk_i,
    input  logic clear_i,
    input  logic d_i,
    output logic q_o,
    output logic q_no
);

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            q_o <= 1'b0;
        end else begin
            q_o <= d_i;
        end
    end

    assign q_no = ~q_o;

endmodule

// File: rtl/mod_n_down_counter.sv
// Synchronous mod-N down counter with parallel load, borrow pulse and load range error.
// Build option MOD_N_DOWN_SAT_EN: saturate at zero and add a sticky underflow_o flag.
module mod_n_down_counter
    import mod_n_pkg::*;
#(
    parameter int N = 5,
    parameter int W = cnt_width(N)
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         decr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o,
    output logic         zero_o,
    output logic         borrow_o,
    output logic         load_err_o
`ifdef MOD_N_DOWN_SAT_EN
    ,
    output logic         underflow_o
`endif
);

    generate
        if (N < MOD_N_MIN || N > MOD_N_MAX) begin : g_bad_modulus
            $error("mod_n_down_counter: N=%0d outside %0d..%0d", N, MOD_N_MIN, MOD_N_MAX);
        end
    endgenerate

    localparam logic [W-1:0] MAX_CNT = W'(N - 1);
    localparam logic [W:0]   N_EXT   = (W + 1)'(N);

    logic [W-1:0] count;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] cnt_n;
    logic         borrow_nxt;
    logic         load_err_nxt;
    logic [W+1:0] d_vec;
    logic [W+1:0] q_vec;
    logic [1:0]   ctl_n_unused;

`ifdef MOD_N_DOWN_SAT_EN
    logic uflow_q;
    logic uflow_nxt;
`endif

    always_comb begin
        cnt_nxt      = count;
        borrow_nxt   = 1'b0;
        load_err_nxt = 1'b0;
`ifdef MOD_N_DOWN_SAT_EN
        uflow_nxt    = uflow_q;
`endif
        if (load_i) begin
`ifdef MOD_N_DOWN_SAT_EN
            uflow_nxt = 1'b0;
`endif
            if ({1'b0, load_val_i} < N_EXT) begin
                cnt_nxt = load_val_i;
            end else begin
                cnt_nxt      = MAX_CNT;
                load_err_nxt = 1'b1;
            end
        end else if (decr_i) begin
            // Unreachable codes above N-1 recover to N-1 without a borrow.
            if (count > MAX_CNT) begin
                cnt_nxt = MAX_CNT;
            end else if (count == '0) begin
`ifdef MOD_N_DOWN_SAT_EN
                cnt_nxt   = '0;
                uflow_nxt = 1'b1;
`else
                cnt_nxt    = MAX_CNT;
                borrow_nxt = 1'b1;
`endif
            end else begin
                cnt_nxt = count - W'(1);
            end
        end
    end

    // State register: count bits, then borrow, then load error.
    assign d_vec = {load_err_nxt, borrow_nxt, cnt_nxt};

    generate
        for (genvar i = 0; i < W + 2; i++) begin : g_flop
            if (i < W) begin : g_cnt
                d_ff_sync u_ff (
                    .clk_i   (clk_i),
                    .clear_i (clear_i),
                    .d_i     (d_vec[i]),
                    .q_o     (q_vec[i]),
                    .q_no    (cnt_n[i])
                );
            end else begin : g_ctl
                d_ff_sync u_ff (
                    .clk_i   (clk_i),
                    .clear_i (clear_i),
                    .d_i     (d_vec[i]),
                    .q_o     (q_vec[i]),
                    .q_no    (ctl_n_unused[i-W])
                );
            end
        end
    endgenerate

    assign count      = q_vec[W-1:0];
    assign count_o    = count;
    assign borrow_o   = q_vec[W];
    assign load_err_o = q_vec[W+1];
    // All inverted count bits high means the count is zero.
    assign zero_o     = &cnt_n;

`ifdef MOD_N_DOWN_SAT_EN
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            uflow_q <= 1'b0;
        end else begin
            uflow_q <= uflow_nxt;
        end
    end

    assign underflow_o = uflow_q;
`endif

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Self-checking bench for mod_n_down_counter (N=5 unit plus a two-stage N=10 cascade).
module tb_mod_n_down_counter;

    localparam int N  = 5;
    localparam int W  = 3;
    localparam int NC = 10;
    localparam int WC = 4;

    typedef struct {
        int cnt;
        int bor;
        int lerr;
        int uf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         clear = 1'b0;
    logic         load  = 1'b0;
    logic         decr  = 1'b0;
    logic [W-1:0] lval  = '0;
    logic [W-1:0] count;
    logic         zero;
    logic         borrow;
    logic         lerr;
`ifdef MOD_N_DOWN_SAT_EN
    logic         uf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    int   m_cnt  = 0;
    int   m_bor  = 0;
    int   m_lerr = 0;
    int   m_uf   = 0;

    mod_n_down_counter #(.N(N)) u_dut (
        .clk_i      (clk),
        .clear_i    (clear),
        .decr_i     (decr),
        .load_i     (load),
        .load_val_i (lval),
        .count_o    (count),
        .zero_o     (zero),
        .borrow_o   (borrow),
        .load_err_o (lerr)
`ifdef MOD_N_DOWN_SAT_EN
        ,
        .underflow_o(uf)
`endif
    );

`ifndef MOD_N_DOWN_SAT_EN
    logic          c_clear = 1'b0;
    logic          c_load  = 1'b0;
    logic          c_decr  = 1'b0;
    logic [WC-1:0] c_lval  = '0;
    logic [WC-1:0] lo_cnt, hi_cnt;
    logic          lo_zero, hi_zero, lo_bor, hi_bor, lo_lerr, hi_lerr;

    mod_n_down_counter #(.N(NC)) u_lo (
        .clk_i      (clk),
        .clear_i    (c_clear),
        .decr_i     (c_decr),
        .load_i     (c_load),
        .load_val_i (c_lval),
        .count_o    (lo_cnt),
        .zero_o     (lo_zero),
        .borrow_o   (lo_bor),
        .load_err_o (lo_lerr)
    );

    mod_n_down_counter #(.N(NC)) u_hi (
        .clk_i      (clk),
        .clear_i    (c_clear),
        .decr_i     (lo_bor),
        .load_i     (c_load),
        .load_val_i (c_lval),
        .count_o    (hi_cnt),
        .zero_o     (hi_zero),
        .borrow_o   (hi_bor),
        .load_err_o (hi_lerr)
    );

    task automatic cstep(input logic c, input logic l, input logic d);
        @(negedge clk);
        c_clear = c;
        c_load  = l;
        c_decr  = d;
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, push the reference result, compare after the edge.
    task automatic step(input logic c, input logic l, input logic d, input int v);
        exp_t e;
        @(negedge clk);
        clear = c;
        load  = l;
        decr  = d;
        lval  = v[W-1:0];
        if (c) begin
            m_cnt = 0; m_bor = 0; m_lerr = 0; m_uf = 0;
        end else if (l) begin
            m_bor = 0;
            m_uf  = 0;
            if (v < N) begin
                m_cnt = v; m_lerr = 0;
            end else begin
                m_cnt = N - 1; m_lerr = 1;
            end
        end else if (d) begin
            m_lerr = 0;
            if (m_cnt == 0) begin
`ifdef MOD_N_DOWN_SAT_EN
                m_bor = 0; m_uf = 1;
`else
                m_cnt = N - 1; m_bor = 1;
`endif
            end else begin
                m_cnt = m_cnt - 1; m_bor = 0;
            end
        end else begin
            m_bor = 0; m_lerr = 0;
        end
        sb_q.push_back('{m_cnt, m_bor, m_lerr, m_uf});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("count", int'(count), e.cnt);
        chk("zero", int'(zero), int'(e.cnt == 0));
        chk("borrow", int'(borrow), e.bor);
        chk("load_err", int'(lerr), e.lerr);
`ifdef MOD_N_DOWN_SAT_EN
        chk("underflow", int'(uf), e.uf);
`endif
    endtask

    initial begin
        int wexp[6] = '{4, 3, 2, 1, 0, 4};
        int wbor[6] = '{1, 0, 0, 0, 0, 1};

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_zero", int'(zero), 1);

`ifndef MOD_N_DOWN_SAT_EN
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 1, 0);
            chk("wrap_seq", int'(count), wexp[k]);
            chk("wrap_borrow", int'(borrow), wbor[k]);
        end
`endif

        step(0, 1, 0, 3);
        chk("load3", int'(count), 3);
        step(0, 1, 0, 7);
        chk("load7", int'(count), 4);
        chk("load7_err", int'(lerr), 1);
        step(0, 0, 0, 0);
        chk("load_err_pulse", int'(lerr), 0);

        step(0, 1, 0, 2);
        step(0, 1, 1, 1);
        chk("prio_load", int'(count), 1);
        chk("prio_borrow", int'(borrow), 0);
        step(1, 1, 0, 3);
        chk("prio_clear", int'(count), 0);

`ifdef MOD_N_DOWN_SAT_EN
        step(0, 1, 0, 1);
        step(0, 0, 1, 0);
        chk("sat_d1", int'(uf), 0);
        step(0, 0, 1, 0);
        chk("sat_d2", int'(uf), 1);
        step(0, 0, 1, 0);
        chk("sat_d3_cnt", int'(count), 0);
        chk("sat_d3_bor", int'(borrow), 0);
        step(0, 1, 0, 2);
        chk("sat_load_clr", int'(uf), 0);
`endif

        for (int k = 0; k < 60; k++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));
        end

`ifndef MOD_N_DOWN_SAT_EN
        cstep(1, 0, 0);
        cstep(1, 0, 0);
        cstep(0, 1, 0);
        chk("casc_lo_ld", int'(lo_cnt), 0);
        chk("casc_hi_ld", int'(hi_cnt), 0);
        cstep(0, 0, 1);
        chk("casc_lo_first", int'(lo_cnt), 9);
        chk("casc_hi_skew", int'(hi_cnt), 0);
        for (int k = 2; k <= 100; k++) begin
            cstep(0, 0, 1);
            if (k == 2) chk("casc_hi_first", int'(hi_cnt), 9);
            chk("casc_lo_seq", int'(lo_cnt), (NC - (k % NC)) % NC);
        end
        cstep(0, 0, 0);
        chk("casc_lo_end", int'(lo_cnt), 0);
        chk("casc_hi_end", int'(hi_cnt), 0);
        chk("casc_zero", int'(lo_zero & hi_zero), 1);
        chk("casc_flags", int'(hi_bor | lo_lerr | hi_lerr), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
